// File: rtl/pipe_regs_pkg.sv
// Shared definitions for the multi-channel register pipeline: stage-0 transform
// selector encoding and the width-generic transform function.
package pipe_regs_pkg;

  typedef enum logic [1:0] {
    FUNC_PASS = 2'd0,
    FUNC_INV  = 2'd1,
    FUNC_REV  = 2'd2,
    FUNC_SWAP = 2'd3
  } func_e;

  localparam int unsigned FUNC_MAX_W = 64;

  // Operates on the low w bits of a FUNC_MAX_W-bit container; bits above w return zero.
  function automatic logic [FUNC_MAX_W-1:0] apply_func(input logic [FUNC_MAX_W-1:0] x,
                                                       input int unsigned           w,
                                                       input func_e                 sel);
    logic [FUNC_MAX_W-1:0] mask;
    logic [FUNC_MAX_W-1:0] xm;
    logic [FUNC_MAX_W-1:0] r;
    int unsigned           h;
    mask = (w >= FUNC_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    xm   = x & mask;
    h    = w / 2;
    r    = xm;
    case (sel)
      FUNC_INV: r = ~xm & mask;
      FUNC_REV: begin
        r = '0;
        for (int unsigned i = 0; i < FUNC_MAX_W; i++) begin
          if (i < w) r[6'(i)] = xm[6'(w - 1 - i)];
        end
      end
      FUNC_SWAP: begin
        if (w[0] == 1'b0) r = ((xm >> h) | (xm << h)) & mask;
      end
      default: r = xm;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: valid flag plus data word with load enable, flush and
// synchronous active-low reset. Data only moves when the incoming word is valid.
module pipe_stage
  import pipe_regs_pkg::*;
#(
  parameter int unsigned WIDTH_T = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic               valid_i,
  input  logic [WIDTH_T-1:0] data_i,
  output logic               valid_o,
  output logic [WIDTH_T-1:0] data_o
);

  logic               valid_q, valid_d;
  logic [WIDTH_T-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i && valid_i) data_d = data_i;
    if (flush_i)     valid_d = 1'b0;
    else if (load_i) valid_d = valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_regs_mc.sv
// CH-channel, DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapsing, synchronous flush and a per-channel transform at stage 0.
module pipe_regs_mc
  import pipe_regs_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FLUSH,
  input  logic [1:0]                   FUNC_SEL,
  input  logic                         IN_VALID,
  output logic                         IN_READY,
  input  logic [CH*WIDTH-1:0]          IN_DATA,
  input  logic [CH-1:0]                CH_EN,
  output logic                         OUT_VALID,
  input  logic                         OUT_READY,
  output logic [CH*WIDTH-1:0]          OUT_DATA,
  output logic [$clog2(DEPTH+1)-1:0]   OCC
);

  localparam int unsigned     DW       = CH * WIDTH;
  localparam int unsigned     OCC_W    = $clog2(DEPTH + 1);
  localparam logic [DEPTH-1:0] ALL_ONES = '1;

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_up;
  logic [DEPTH-1:0] v_nxt;
  logic [DEPTH-1:0] permit;
  logic [DW-1:0]    d [DEPTH];
  logic [DW-1:0]    stage0_data;
  logic [OCC_W-1:0] occ_q, occ_d;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [FUNC_MAX_W-1:0] xf_full;
    assign xf_full = apply_func(64'(IN_DATA[c*WIDTH +: WIDTH]), WIDTH, func_e'(FUNC_SEL));
    assign stage0_data[c*WIDTH +: WIDTH] = CH_EN[c] ? xf_full[WIDTH-1:0] : '0;
    if (WIDTH < FUNC_MAX_W) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^xf_full[FUNC_MAX_W-1:WIDTH];
    end
  end

  // Stage k may load unless it and every later stage are full with no output
  // transfer; written in closed form to keep the ready chain free of feedback.
  for (genvar k = 0; k < DEPTH; k++) begin : g_permit
    assign permit[k] = OUT_READY || ((v >> k) != (ALL_ONES >> k));
  end

  assign v_up = (v << 1) | DEPTH'(IN_VALID);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [DW-1:0] din;
    if (k == 0) begin : g_first
      assign din = stage0_data;
    end else begin : g_next
      assign din = d[k-1];
    end
    pipe_stage #(.WIDTH_T(DW)) u_stage (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .flush_i (FLUSH),
      .load_i  (permit[k]),
      .valid_i (v_up[k]),
      .data_i  (din),
      .valid_o (v[k]),
      .data_o  (d[k])
    );
  end

  always_comb begin
    v_nxt = FLUSH ? '0 : ((permit & v_up) | (~permit & v));
    occ_d = OCC_W'($countones(v_nxt));
  end

  always_ff @(posedge CLK) begin
    if (!RST) occ_q <= '0;
    else      occ_q <= occ_d;
  end

  assign IN_READY  = permit[0];
  assign OUT_VALID = v[DEPTH-1];
  assign OUT_DATA  = d[DEPTH-1];
  assign OCC       = occ_q;

endmodule
